// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if: bundles the instruction-memory request/response bus,
// the decode-side valid/ready handshake and the redirect request.
//   master modport : the fetch unit (drives imem request and decode output)
//   slave modport  : the environment (memory, decode and branch logic)
interface fetch_queue_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_gnt_i;
  logic              imem_rvalid_i;
  logic [XLEN-1:0]   imem_rdata_i;
  logic              instr_valid_o;
  logic [XLEN-1:0]   instr_o;
  logic [ADDR_W-1:0] instr_pc_o;
  logic              instr_ready_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
           redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
           redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: owns the fetch PC, requests instructions from memory
// (grant handshake, fixed 1-cycle read latency) and buffers the returned
// instructions with their PCs in a QDEPTH-entry queue for decode.
//   clk_i   : clock, all state on rising edge
//   rst_i   : synchronous active-low reset
//   start_i : fetch enable (level)
//   busy_o  : RUN state, request in flight, or queue non-empty
//   bus     : imem request/response, decode handshake, redirect
module fetch_queue_unit #(
  parameter int                XLEN     = 32,
  parameter int                ADDR_W   = 32,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 busy_o,
  fetch_queue_unit_if.master   bus
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] tag_q;
  logic              outstanding_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [XLEN-1:0]   instr_mem_q [QDEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [QDEPTH];

  logic credit_ok_s;
  logic req_s;
  logic grant_s;
  logic push_s;
  logic valid_s;
  logic pop_s;
  logic nonempty_s;

  // Credit counts the in-flight request so a response always finds a free slot.
  assign credit_ok_s = (count_q + CNT_W'(outstanding_q)) < CNT_W'(QDEPTH);
  assign req_s       = (state_q == ST_RUN) & start_i & ~bus.redirect_i & credit_ok_s;
  assign grant_s     = req_s & bus.imem_gnt_i;
  // A response without a pending request (e.g. right after reset) is dropped.
  assign push_s      = bus.imem_rvalid_i & outstanding_q & ~bus.redirect_i;
  assign nonempty_s  = (count_q != CNT_W'(0));
  assign valid_s     = nonempty_s & ~bus.redirect_i;
  assign pop_s       = valid_s & bus.instr_ready_i;

  assign bus.imem_req_o    = req_s;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = valid_s;
  // Head data is masked when empty so stale entries never leak out.
  assign bus.instr_o       = nonempty_s ? instr_mem_q[head_q] : '0;
  assign bus.instr_pc_o    = nonempty_s ? pc_mem_q[head_q]    : '0;
  assign busy_o            = (state_q == ST_RUN) | outstanding_q | nonempty_s;

  // FSM, fetch PC, outstanding tracking and queue storage.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= RESET_PC;
      tag_q         <= '0;
      outstanding_q <= 1'b0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= start_i ? ST_RUN : ST_IDLE;
        ST_RUN:  state_q <= start_i ? ST_RUN : ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      if (bus.redirect_i) begin
        // Flush everything buffered or in flight and retarget, word aligned.
        fetch_pc_q    <= {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
        outstanding_q <= 1'b0;
        count_q       <= '0;
        head_q        <= '0;
        tail_q        <= '0;
      end else begin
        if (grant_s) begin
          fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
          tag_q      <= fetch_pc_q;
        end
        // Back-to-back grants keep outstanding set across the response.
        if (grant_s) begin
          outstanding_q <= 1'b1;
        end else if (push_s) begin
          outstanding_q <= 1'b0;
        end
        if (push_s) begin
          instr_mem_q[tail_q] <= bus.imem_rdata_i;
          pc_mem_q[tail_q]    <= tag_q;
          tail_q              <= tail_q + PTR_W'(1);
        end
        if (pop_s) begin
          head_q <= head_q + PTR_W'(1);
        end
        count_q <= count_q + CNT_W'(push_s) - CNT_W'(pop_s);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed testbench for fetch_queue_unit. A small memory responder inside
// tick() answers every granted request one cycle later with addr^A5A5_0000.
module tb_fetch_queue_unit;
  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  int   tests;
  int   fails;

  fetch_queue_unit_if #(.XLEN(32), .ADDR_W(32)) bus ();

  fetch_queue_unit #(
    .XLEN(32), .ADDR_W(32), .QDEPTH(4), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .start_i (start),
    .busy_o  (busy),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; the response to a grant seen this cycle appears after the edge.
  task automatic tick();
    logic        g;
    logic [31:0] a;
    #1;
    g = bus.imem_req_o & bus.imem_gnt_i;
    a = bus.imem_addr_o;
    @(posedge clk);
    #1;
    bus.imem_rvalid_i = g;
    bus.imem_rdata_i  = a ^ 32'hA5A5_0000;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n                = 1'b0;
    start                = 1'b0;
    bus.imem_gnt_i       = 1'b0;
    bus.instr_ready_i    = 1'b0;
    bus.redirect_i       = 1'b0;
    bus.redirect_pc_i    = 32'h0000_0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0000_0000;
    bus.instr_ready_i = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0000_0000;

    // Reset state
    do_reset();
    chk1("rst_valid", bus.instr_valid_o, 1'b0);
    chk1("rst_req",   bus.imem_req_o,    1'b0);
    chk1("rst_busy",  busy,              1'b0);
    chk ("rst_instr", bus.instr_o,       32'h0000_0000);
    chk ("rst_pc",    bus.instr_pc_o,    32'h0000_0000);
    chk ("rst_addr",  bus.imem_addr_o,   32'h0000_0000);

    // Streaming: one instruction per cycle, first valid 2 cycles after grant
    start = 1'b1; bus.imem_gnt_i = 1'b1; bus.instr_ready_i = 1'b1;
    tick();
    chk1("s_req1",   bus.imem_req_o,    1'b1);
    chk ("s_addr1",  bus.imem_addr_o,   32'h0000_0000);
    tick();
    chk1("s_valid2", bus.instr_valid_o, 1'b0);
    chk ("s_addr2",  bus.imem_addr_o,   32'h0000_0004);
    tick();
    chk1("s_valid3", bus.instr_valid_o, 1'b1);
    chk ("s_pc3",    bus.instr_pc_o,    32'h0000_0000);
    chk ("s_ins3",   bus.instr_o,       32'hA5A5_0000);
    tick();
    chk ("s_pc4",    bus.instr_pc_o,    32'h0000_0004);
    tick();
    chk ("s_pc5",    bus.instr_pc_o,    32'h0000_0008);
    tick();
    chk ("s_pc6",    bus.instr_pc_o,    32'h0000_000C);
    chk ("s_ins6",   bus.instr_o,       32'hA5A5_000C);

    // Full queue with ready low
    do_reset();
    start = 1'b1; bus.imem_gnt_i = 1'b1; bus.instr_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk1("f_valid",  bus.instr_valid_o, 1'b1);
    chk ("f_head",   bus.instr_pc_o,    32'h0000_0000);
    chk1("f_req",    bus.imem_req_o,    1'b0);
    chk ("f_addr",   bus.imem_addr_o,   32'h0000_0010);
    tick();
    chk1("f_req_hold", bus.imem_req_o,  1'b0);
    chk ("f_head_hold", bus.instr_pc_o, 32'h0000_0000);
    bus.instr_ready_i = 1'b1;
    tick();
    bus.instr_ready_i = 1'b0;
    chk ("f_pop_head", bus.instr_pc_o,  32'h0000_0004);
    chk1("f_req_free", bus.imem_req_o,  1'b1);
    chk ("f_addr16",   bus.imem_addr_o, 32'h0000_0010);
    tick();
    chk1("f_req_full2", bus.imem_req_o, 1'b0);
    chk ("f_addr20",   bus.imem_addr_o, 32'h0000_0014);
    tick();
    chk ("f_head4",    bus.instr_pc_o,  32'h0000_0004);
    bus.instr_ready_i = 1'b1;
    tick();
    chk ("f_head8",    bus.instr_pc_o,  32'h0000_0008);
    tick();
    chk ("f_head12",   bus.instr_pc_o,  32'h0000_000C);
    tick();
    chk ("f_head16",   bus.instr_pc_o,  32'h0000_0010);
    chk ("f_ins16",    bus.instr_o,     32'hA5A5_0010);

    // Redirect with 3 entries queued and a response in flight
    do_reset();
    start = 1'b1; bus.imem_gnt_i = 1'b1; bus.instr_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk ("r_pre_head", bus.instr_pc_o, 32'h0000_0000);
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0103;
    #1;
    chk1("r_valid_cyc", bus.instr_valid_o, 1'b0);
    chk1("r_req_cyc",   bus.imem_req_o,    1'b0);
    tick();
    bus.redirect_i = 1'b0;
    bus.instr_ready_i = 1'b1;
    #1;
    chk1("r_valid_next", bus.instr_valid_o, 1'b0);
    chk1("r_req_next",   bus.imem_req_o,    1'b1);
    chk ("r_addr",       bus.imem_addr_o,   32'h0000_0100);
    tick();
    chk1("r_valid_gnt",  bus.instr_valid_o, 1'b0);
    tick();
    chk1("r_valid_new",  bus.instr_valid_o, 1'b1);
    chk ("r_pc_new",     bus.instr_pc_o,    32'h0000_0100);
    chk ("r_ins_new",    bus.instr_o,       32'hA5A5_0100);

    // Grant withheld: address held, nothing pushed
    do_reset();
    start = 1'b1; bus.imem_gnt_i = 1'b0; bus.instr_ready_i = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk ("g_addr_hold",  bus.imem_addr_o,   32'h0000_0000);
      chk1("g_valid_hold", bus.instr_valid_o, 1'b0);
    end
    bus.imem_gnt_i = 1'b1;
    tick();
    chk ("g_addr4", bus.imem_addr_o, 32'h0000_0004);
    tick();
    chk ("g_pc0",   bus.instr_pc_o,  32'h0000_0000);
    tick();
    chk ("g_pc4",   bus.instr_pc_o,  32'h0000_0004);

    // Stop fetching with 2 queued and 1 outstanding, drain, then resume
    do_reset();
    start = 1'b1; bus.imem_gnt_i = 1'b1; bus.instr_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    start = 1'b0;
    #1;
    chk1("p_req_off", bus.imem_req_o, 1'b0);
    tick();
    chk1("p_busy1",   busy,              1'b1);
    chk ("p_head0",   bus.instr_pc_o,    32'h0000_0000);
    bus.instr_ready_i = 1'b1;
    tick();
    chk ("p_head4",   bus.instr_pc_o,    32'h0000_0004);
    tick();
    chk ("p_head8",   bus.instr_pc_o,    32'h0000_0008);
    chk1("p_busy2",   busy,              1'b1);
    tick();
    chk1("p_empty",   bus.instr_valid_o, 1'b0);
    chk1("p_busy0",   busy,              1'b0);
    chk1("p_noreq",   bus.imem_req_o,    1'b0);
    start = 1'b1; bus.instr_ready_i = 1'b0;
    tick();
    chk1("p_req_on",  bus.imem_req_o,    1'b1);
    chk ("p_addr12",  bus.imem_addr_o,   32'h0000_000C);

    // Reset mid-stream with a response arriving the cycle after reset
    do_reset();
    start = 1'b1; bus.imem_gnt_i = 1'b1; bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk1("m_rvalid_arrives", bus.imem_rvalid_i, 1'b1);
    chk1("m_valid0",  bus.instr_valid_o, 1'b0);
    chk ("m_addr0",   bus.imem_addr_o,   32'h0000_0000);
    chk1("m_busy0",   busy,              1'b0);
    tick();
    chk1("m_ignored", bus.instr_valid_o, 1'b0);
    chk1("m_req",     bus.imem_req_o,    1'b1);
    tick();
    tick();
    chk1("m_valid",   bus.instr_valid_o, 1'b1);
    chk ("m_pc0",     bus.instr_pc_o,    32'h0000_0000);

    // Fetch PC wrap at the top of the address space
    do_reset();
    start = 1'b1; bus.imem_gnt_i = 1'b0; bus.instr_ready_i = 1'b1;
    tick();
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    bus.redirect_i = 1'b0;
    #1;
    chk ("w_addr_top", bus.imem_addr_o, 32'hFFFF_FFFC);
    bus.imem_gnt_i = 1'b1;
    tick();
    chk ("w_addr_wrap", bus.imem_addr_o, 32'h0000_0000);
    tick();
    chk ("w_pc_top",  bus.instr_pc_o,   32'hFFFF_FFFC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised successor to the single-cycle PC / Add_PC / Instruction_Memory fetch path.
- Owns the fetch PC and issues requests to an instruction memory with a grant handshake and a fixed 1-cycle read latency.
- Buffers returned instructions with their PCs in a QDEPTH-entry queue, presented to decode through a valid/ready handshake.
- Supports start/stop and a branch/jump redirect that flushes all buffered and in-flight instructions.

Parameters:
XLEN, 32, instruction width in bits
ADDR_W, 32, PC / memory address width in bits
QDEPTH, 4, queue entries (power of 2, >=2)
RESET_PC, 0, fetch PC loaded on reset (low 2 bits must be 0)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous reset, active-low
start_i  in  1  fetch enable, level-sensitive
imem_req_o  out  1  fetch request valid
imem_addr_o  out  ADDR_W  request address (current fetch PC)
imem_gnt_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  read data valid, exactly 1 cycle after a grant
imem_rdata_i  in  XLEN  read data
instr_valid_o  out  1  queue head valid
instr_o  out  XLEN  queue head instruction
instr_pc_o  out  ADDR_W  queue head PC
instr_ready_i  in  1  decode consumes head
redirect_i  in  1  flush and restart fetch
redirect_pc_i  in  ADDR_W  new fetch target
busy_o  out  1  state RUN, or in-flight request, or queue non-empty

Behaviour:
- Reset (rst_i=0 at posedge): fetch_pc=RESET_PC, queue empty (count=0), outstanding=0, state=IDLE. Outputs: instr_valid_o=0, imem_req_o=0, busy_o=0, instr_o/instr_pc_o=0. Reset overrides every other input.
- FSM states: IDLE, RUN.
  - IDLE->RUN when start_i=1.
  - RUN->IDLE when start_i=0. In IDLE no requests issue; the queue still drains and any outstanding response is still accepted.
  - Fetch resumes from the held fetch_pc.
- Request (combinational): imem_req_o = RUN & start_i & !redirect_i & (count + outstanding < QDEPTH). imem_addr_o = fetch_pc.
- Grant (req & gnt): fetch_pc <= fetch_pc + 4, wrapping mod 2^ADDR_W. outstanding <= 1 and the PC is latched as a tag. At most one request is outstanding; back-to-back grants are allowed because the response returns the next cycle.
- Response:
  - imem_rvalid_i with outstanding=1 and no redirect pushes {tag PC, rdata} at the tail; outstanding clears unless a new grant occurs in the same cycle.
  - imem_rvalid_i with outstanding=0 is ignored.
  - The credit rule guarantees no overflow.
- Output: instr_valid_o = (count!=0) & !redirect_i. instr_o and instr_pc_o come from the head entry. Pop when instr_valid_o & instr_ready_i.
- Simultaneous push and pop: count is unchanged; legal when full, and when empty the push is not bypassed.
- Latency: grant at cycle N, data at N+1, visible at instr_valid_o at N+2 (no bypass).
- Redirect (highest priority after reset):
  - Queue cleared and any same-cycle rvalid discarded.
  - outstanding <= 0.
  - fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00}.
  - No request and no pop occur in the redirect cycle.
  - The first request to the new PC can issue the next cycle if RUN & start_i.
  - Redirect in IDLE updates fetch_pc only.
- Boundaries:
  - Full with an outstanding request: req stays low until a pop frees a slot.
  - Empty: instr_valid_o=0.
  - fetch_pc at 2^ADDR_W-4 wraps to 0.
  - Reset mid-operation: a response arriving the cycle after reset is ignored because outstanding=0.
- busy_o is registered-state derived with no combinational input path.

Test Plan:
- Reset, start_i=1, gnt=1 always, rvalid 1 cycle later with rdata=addr^32'hA5A5_0000, ready=1 -> instr_pc_o sequence 0,4,8,12…; first instr_valid_o 2 cycles after first grant; one instruction per cycle thereafter.
- ready=0 with QDEPTH=4 -> exactly 4 entries buffered (PCs 0,4,8,12), imem_req_o low. ready=1 for 1 cycle -> pop PC 0, one new request to 16, no overflow or loss.
- Redirect to 0x103 while queue holds 3 entries and a response is in flight -> instr_valid_o=0 in that cycle and the next; in-flight data dropped; next request addr=0x100; next delivered instr_pc_o=0x100.
- gnt held low for 5 cycles -> imem_addr_o stable, fetch_pc unchanged, no push. Then gnt=1 -> fetch continues in order.
- Drop start_i with 2 entries queued and 1 outstanding -> no new requests; 3 instructions delivered; busy_o falls after the last pop. Reassert start_i -> next request at the following PC.
- Reset asserted for 1 cycle mid-stream with rvalid arriving the next cycle -> queue empty, rvalid ignored, imem_addr_o=RESET_PC.
